pipe_hazard_ctrl: RTL and testbench

Central pipeline controller for the 5-stage ARM core. It detects RAW hazards in ID and drives the flush input of the ID/EX stage register plus the freeze/flush controls of PC and IF/ID. It also squashes wrong-path instructions on taken branches and freezes the whole pipeline while the data-memory (SRAM) handshake is pending. A saturating stall-cycle counter and a sticky memory-timeout flag are provided for debug.

---
 rtl/pipe_ctrl_pkg.sv | 24 ++
 rtl/hazard_detect.sv | 57 +++++
 rtl/pipe_hazard_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   mem_state_e : SRAM handshake FSM encoding (RUN / MEM_WAIT / ERR)
//   FWD_*       : operand-select encoding for fwd_sel1/fwd_sel2
//   fwd_pick    : forwarding-source priority helper
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } mem_state_e;

  localparam logic [1:0] FWD_REG = 2'd0;
  localparam logic [1:0] FWD_MEM = 2'd1;
  localparam logic [1:0] FWD_WB  = 2'd2;

  // The younger result (MEM stage) wins over the older one (WB stage).
  function automatic logic [1:0] fwd_pick(input logic mem_hit, input logic wb_hit);
    if (mem_hit)     return FWD_MEM;
    else if (wb_hit) return FWD_WB;
    else             return FWD_REG;
  endfunction

endpackage

// File: rtl/hazard_detect.sv
// Combinational RAW hazard / forwarding decode for the instruction in ID.
// Build option: FORWARDING_EN
//   undefined : stall on any EXE/MEM destination match, no forwarding
//   defined   : stall only on load-use in EXE, produce operand selects
// Ports:
//   i_src1/i_src2, i_two_src, i_id_valid : ID instruction operands
//   i_exe_*, i_mem_*, (i_wb_*)           : downstream writers
//   o_hazard                             : ID must stall
//   o_fwd_sel1/o_fwd_sel2                : operand source select
module hazard_detect
  import pipe_ctrl_pkg::*;
#(
  parameter int AW = 4
) (
  input  logic [AW-1:0] i_src1,
  input  logic [AW-1:0] i_src2,
  input  logic          i_two_src,
  input  logic          i_id_valid,
  input  logic          i_exe_wb_en,
  input  logic [AW-1:0] i_exe_dest,
  input  logic          i_mem_wb_en,
  input  logic [AW-1:0] i_mem_dest,
`ifdef FORWARDING_EN
  input  logic          i_exe_mem_r_en,
  input  logic          i_wb_wb_en,
  input  logic [AW-1:0] i_wb_dest,
`endif
  output logic          o_hazard,
  output logic [1:0]    o_fwd_sel1,
  output logic [1:0]    o_fwd_sel2
);

  logic w_exe_s1, w_exe_s2, w_mem_s1, w_mem_s2;

  assign w_exe_s1 = i_exe_wb_en & (i_exe_dest == i_src1);
  assign w_exe_s2 = i_exe_wb_en & (i_exe_dest == i_src2);
  assign w_mem_s1 = i_mem_wb_en & (i_mem_dest == i_src1);
  assign w_mem_s2 = i_mem_wb_en & (i_mem_dest == i_src2);

`ifdef FORWARDING_EN
  logic w_wb_s1, w_wb_s2;

  assign w_wb_s1 = i_wb_wb_en & (i_wb_dest == i_src1);
  assign w_wb_s2 = i_wb_wb_en & (i_wb_dest == i_src2);

  // Only a load in EXE cannot be forwarded in time.
  assign o_hazard   = i_id_valid & i_exe_mem_r_en & (w_exe_s1 | (i_two_src & w_exe_s2));
  assign o_fwd_sel1 = fwd_pick(w_mem_s1, w_wb_s1);
  assign o_fwd_sel2 = fwd_pick(w_mem_s2, w_wb_s2);
`else
  // WB is never checked: the regfile writes on negedge, so ID reads the new value.
  assign o_hazard   = i_id_valid & (w_exe_s1 | w_mem_s1 | (i_two_src & (w_exe_s2 | w_mem_s2)));
  assign o_fwd_sel1 = FWD_REG;
  assign o_fwd_sel2 = FWD_REG;
`endif

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central pipeline controller for the 5-stage core: RAW stall, branch
// squash, SRAM-wait freeze, stall-cycle counter and sticky SRAM timeout.
// Build option: FORWARDING_EN (adds wb_wb_en/wb_dest, load-use-only stall,
// live fwd_sel outputs).
// Parameters:
//   ADDRESS_LEN_REG_FILE : register index width
//   MEM_TIMEOUT          : max freeze cycles before ERR (must be >= 2)
//   STALL_CNT_W          : stall counter width
// Ports:
//   clk, rst (async active low)
//   src1/src2/two_src/id_valid      : ID instruction
//   exe_*, mem_*, (wb_*)            : downstream stage info
//   mem_req/mem_ready               : SRAM handshake of the MEM stage
//   branch_taken                    : taken branch resolved in EXE
//   clr_stats                       : clears stall_cnt and mem_err
//   freeze_if/flush_if/flush_id     : front-end controls
//   freeze_all                      : hold every stage register
//   fwd_sel1/fwd_sel2               : operand selects
//   stall_cnt/mem_err               : debug status
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int ADDRESS_LEN_REG_FILE = 4,
  parameter int MEM_TIMEOUT          = 64,
  parameter int STALL_CNT_W          = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src1,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] src2,
  input  logic                            two_src,
  input  logic                            id_valid,
  input  logic                            exe_wb_en,
  input  logic                            exe_mem_r_en,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] exe_dest,
  input  logic                            mem_wb_en,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] mem_dest,
`ifdef FORWARDING_EN
  input  logic                            wb_wb_en,
  input  logic [ADDRESS_LEN_REG_FILE-1:0] wb_dest,
`endif
  input  logic                            mem_req,
  input  logic                            mem_ready,
  input  logic                            branch_taken,
  input  logic                            clr_stats,
  output logic                            freeze_if,
  output logic                            flush_if,
  output logic                            flush_id,
  output logic                            freeze_all,
  output logic [1:0]                      fwd_sel1,
  output logic [1:0]                      fwd_sel2,
  output logic [STALL_CNT_W-1:0]          stall_cnt,
  output logic                            mem_err
);

  localparam int                WCNT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WCNT_W-1:0] WCNT_LAST = WCNT_W'(MEM_TIMEOUT - 1);

  mem_state_e             r_state, w_state_nxt;
  logic [WCNT_W-1:0]      r_wcnt, w_wcnt_nxt;
  logic                   w_freeze_raw, w_err_set;
  logic                   w_hazard, w_stall_evt;
  logic [1:0]             w_fwd1, w_fwd2;
  logic [STALL_CNT_W-1:0] r_stall_cnt;
  logic                   r_mem_err;

  // ---------------- hazard decode ----------------
  hazard_detect #(.AW(ADDRESS_LEN_REG_FILE)) u_hzd (
    .i_src1         (src1),
    .i_src2         (src2),
    .i_two_src      (two_src),
    .i_id_valid     (id_valid),
    .i_exe_wb_en    (exe_wb_en),
    .i_exe_dest     (exe_dest),
    .i_mem_wb_en    (mem_wb_en),
    .i_mem_dest     (mem_dest),
`ifdef FORWARDING_EN
    .i_exe_mem_r_en (exe_mem_r_en),
    .i_wb_wb_en     (wb_wb_en),
    .i_wb_dest      (wb_dest),
`endif
    .o_hazard       (w_hazard),
    .o_fwd_sel1     (w_fwd1),
    .o_fwd_sel2     (w_fwd2)
  );

`ifndef FORWARDING_EN
  // The load flag only matters for load-use detection with forwarding.
  logic w_unused;
  assign w_unused = exe_mem_r_en;
`endif

  // ---------------- SRAM wait FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= RUN;
      r_wcnt  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_wcnt_nxt   = r_wcnt;
    w_freeze_raw = 1'b0;
    w_err_set    = 1'b0;
    case (r_state)
      RUN: begin
        if (mem_req && !mem_ready) begin
          w_freeze_raw = 1'b1;
          w_state_nxt  = MEM_WAIT;
          w_wcnt_nxt   = WCNT_W'(1);
        end
      end
      MEM_WAIT: begin
        w_freeze_raw = ~mem_ready;
        if (mem_ready) begin
          w_state_nxt = RUN;
        end else if (r_wcnt == WCNT_LAST) begin
          w_state_nxt = ERR;
          w_err_set   = 1'b1;
        end else begin
          w_wcnt_nxt = r_wcnt + WCNT_W'(1);
        end
      end
      // One unfrozen cycle lets the pipeline drain before retrying.
      ERR:     w_state_nxt = RUN;
      default: w_state_nxt = RUN;
    endcase
  end

  // ---------------- control priority ----------------
  // Outputs are gated by rst so the combinational paths also read 0 in reset.
  always_comb begin
    freeze_if  = 1'b0;
    flush_if   = 1'b0;
    flush_id   = 1'b0;
    freeze_all = 1'b0;
    fwd_sel1   = FWD_REG;
    fwd_sel2   = FWD_REG;
    if (rst) begin
      fwd_sel1 = w_fwd1;
      fwd_sel2 = w_fwd2;
      if (w_freeze_raw) begin
        // EXE is held, so a pending branch is re-presented after the wait.
        freeze_all = 1'b1;
      end else if (branch_taken) begin
        flush_if = 1'b1;
        flush_id = 1'b1;
      end else if (w_hazard) begin
        freeze_if = 1'b1;
        flush_id  = 1'b1;
      end
    end
  end

  // ---------------- debug counters ----------------
  assign w_stall_evt = w_freeze_raw | (w_hazard & ~branch_taken);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else if (clr_stats) begin
      r_stall_cnt <= '0;
      r_mem_err   <= 1'b0;
    end else begin
      if (w_stall_evt && (r_stall_cnt != '1))
        r_stall_cnt <= r_stall_cnt + STALL_CNT_W'(1);
      if (w_err_set)
        r_mem_err <= 1'b1;
    end
  end

  assign stall_cnt = r_stall_cnt;
  assign mem_err   = r_mem_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Two instances share all inputs:
// u_dut (16-bit counter) and u_sat (2-bit counter), both MEM_TIMEOUT=4.
module tb_pipe_hazard_ctrl;

  localparam int AW = 4;
`ifdef FORWARDING_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic          clk, rst;
  logic [AW-1:0] src1, src2, exe_dest, mem_dest;
  logic          two_src, id_valid, exe_wb_en, exe_mem_r_en, mem_wb_en;
  logic          mem_req, mem_ready, branch_taken, clr_stats;
`ifdef FORWARDING_EN
  logic          wb_wb_en;
  logic [AW-1:0] wb_dest;
`endif

  logic        freeze_if, flush_if, flush_id, freeze_all, mem_err;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [15:0] stall_cnt;
  logic        s_freeze_if, s_flush_if, s_flush_id, s_freeze_all, s_mem_err;
  logic [1:0]  s_fwd_sel1, s_fwd_sel2;
  logic [1:0]  s_stall_cnt;

  logic [3:0] ctl, s_ctl, fwd, s_fwd;
  assign ctl   = {freeze_if, flush_if, flush_id, freeze_all};
  assign s_ctl = {s_freeze_if, s_flush_if, s_flush_id, s_freeze_all};
  assign fwd   = {fwd_sel1, fwd_sel2};
  assign s_fwd = {s_fwd_sel1, s_fwd_sel2};

  int n_tests = 0;
  int n_fail  = 0;
  int exp_cnt = 0;

  pipe_hazard_ctrl #(.ADDRESS_LEN_REG_FILE(AW), .MEM_TIMEOUT(4), .STALL_CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src), .id_valid(id_valid),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
`ifdef FORWARDING_EN
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
`endif
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken), .clr_stats(clr_stats),
    .freeze_if(freeze_if), .flush_if(flush_if), .flush_id(flush_id), .freeze_all(freeze_all),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cnt(stall_cnt), .mem_err(mem_err)
  );

  pipe_hazard_ctrl #(.ADDRESS_LEN_REG_FILE(AW), .MEM_TIMEOUT(4), .STALL_CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .src1(src1), .src2(src2), .two_src(two_src), .id_valid(id_valid),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_dest(exe_dest),
    .mem_wb_en(mem_wb_en), .mem_dest(mem_dest),
`ifdef FORWARDING_EN
    .wb_wb_en(wb_wb_en), .wb_dest(wb_dest),
`endif
    .mem_req(mem_req), .mem_ready(mem_ready), .branch_taken(branch_taken), .clr_stats(clr_stats),
    .freeze_if(s_freeze_if), .flush_if(s_flush_if), .flush_id(s_flush_id), .freeze_all(s_freeze_all),
    .fwd_sel1(s_fwd_sel1), .fwd_sel2(s_fwd_sel2), .stall_cnt(s_stall_cnt), .mem_err(s_mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ctl = {freeze_if, flush_if, flush_id, freeze_all}
  task automatic chk_ctl(input string tag, input logic [3:0] exp);
    chk(tag, {24'd0, ctl, s_ctl}, {24'd0, exp, exp});
  endtask

  task automatic chk_fwd(input string tag, input logic [3:0] exp);
    chk(tag, {24'd0, fwd, s_fwd}, {24'd0, exp, exp});
  endtask

  task automatic chk_err(input string tag, input logic exp);
    chk(tag, {30'd0, mem_err, s_mem_err}, {30'd0, exp, exp});
  endtask

  task automatic chk_cnt(input string tag);
    chk(tag, {16'd0, stall_cnt}, exp_cnt);
    chk({tag, "_sat"}, {30'd0, s_stall_cnt}, (exp_cnt > 3) ? 3 : exp_cnt);
  endtask

  task automatic idle();
    src1 = '0; src2 = '0; exe_dest = '0; mem_dest = '0;
    two_src = 0; id_valid = 0; exe_wb_en = 0; exe_mem_r_en = 0; mem_wb_en = 0;
    mem_req = 0; mem_ready = 0; branch_taken = 0; clr_stats = 0;
`ifdef FORWARDING_EN
    wb_wb_en = 0; wb_dest = '0;
`endif
  endtask

  // ID reads r3 while a load in EXE writes r3: a stall in every build.
  task automatic load_use();
    id_valid = 1; src1 = 4'd3; exe_wb_en = 1; exe_mem_r_en = 1; exe_dest = 4'd3;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // ---------------- reset: outputs forced low even with active inputs
    rst = 0;
    idle();
    mem_req = 1;
    load_use();
    #12;
    chk_ctl("rst_ctl", 4'b0000);
    chk_fwd("rst_fwd", 4'b0000);
    chk_cnt("rst_cnt");
    chk_err("rst_err", 1'b0);
    @(negedge clk);
    rst = 1;
    idle();
    @(negedge clk);

    // ---------------- RAW on EXE, non-load
    id_valid = 1; src1 = 4'd3; exe_wb_en = 1; exe_dest = 4'd3;
    #1 chk_ctl("raw_exe", FWD ? 4'b0000 : 4'b1010);
    @(negedge clk);
    exp_cnt += FWD ? 0 : 1;
    chk_cnt("raw_exe_cnt");

    // ---------------- load-use on EXE
    exe_mem_r_en = 1;
    #1 chk_ctl("load_use", 4'b1010);
    @(negedge clk);
    exp_cnt += 1;
    chk_cnt("load_use_cnt");

    // ---------------- MEM match on src2, WB match on src1
    idle();
    id_valid = 1; src1 = 4'd0; src2 = 4'd5; two_src = 1;
    mem_wb_en = 1; mem_dest = 4'd5; exe_wb_en = 1; exe_dest = 4'd3;
`ifdef FORWARDING_EN
    wb_wb_en = 1; wb_dest = 4'd0;
`endif
    #1 chk_ctl("raw_mem_s2", FWD ? 4'b0000 : 4'b1010);
    chk_fwd("fwd_mem_wb", FWD ? 4'b1001 : 4'b0000);
    @(negedge clk);
    exp_cnt += FWD ? 0 : 1;
    chk_cnt("raw_mem_s2_cnt");

    // MEM and WB both match src2: MEM wins
`ifdef FORWARDING_EN
    wb_dest = 4'd5;
`endif
    #1 chk_fwd("fwd_mem_prio", FWD ? 4'b0001 : 4'b0000);
    @(negedge clk);
    exp_cnt += FWD ? 0 : 1;

    // ---------------- src2 ignored when two_src = 0
    two_src = 0;
    #1 chk_ctl("one_src", 4'b0000);
    chk_fwd("one_src_fwd", FWD ? 4'b0001 : 4'b0000);
    @(negedge clk);
    chk_cnt("one_src_cnt");

    // ---------------- id_valid = 0 masks hazards
    idle();
    load_use();
    id_valid = 0;
    #1 chk_ctl("no_valid", 4'b0000);
    @(negedge clk);
    chk_cnt("no_valid_cnt");

    // ---------------- branch overrides hazard, not counted
    id_valid = 1; branch_taken = 1;
    #1 chk_ctl("br_hzd", 4'b0110);
    @(negedge clk);
    chk_cnt("br_hzd_cnt");

    idle();
    branch_taken = 1;
    #1 chk_ctl("br_only", 4'b0110);
    @(negedge clk);

    // ---------------- SRAM wait: 3 freeze cycles, freeze beats branch+hazard
    idle();
    mem_req = 1;
    load_use();
    branch_taken = 1;
    #1 chk_ctl("wait_c1", 4'b0001);
    @(negedge clk);
    exp_cnt += 1;
    chk_cnt("wait_c1_cnt");
    idle();
    mem_req = 1;
    #1 chk_ctl("wait_c2", 4'b0001);
    @(negedge clk);
    exp_cnt += 1;
    #1 chk_ctl("wait_c3", 4'b0001);
    @(negedge clk);
    exp_cnt += 1;
    chk_cnt("wait_c3_cnt");
    mem_ready = 1;
    #1 chk_ctl("wait_ready", 4'b0000);
    @(negedge clk);
    chk_cnt("wait_done_cnt");
    chk_err("wait_no_err", 1'b0);
    mem_req = 0; mem_ready = 0;
    #1 chk_ctl("run_after_wait", 4'b0000);
    @(negedge clk);

    // ---------------- timeout: 4 freeze cycles then ERR
    mem_req = 1;
    for (int i = 0; i < 4; i++) begin
      #1 chk_ctl("tmo_freeze", 4'b0001);
      chk_err("tmo_err_pre", 1'b0);
      @(negedge clk);
      exp_cnt += 1;
    end
    chk_err("tmo_err_set", 1'b1);
    #1 chk_ctl("tmo_err_state", 4'b0000);
    chk_cnt("tmo_cnt");
    mem_req = 0;
    @(negedge clk);
    chk_err("tmo_err_sticky", 1'b1);
    #1 chk_ctl("tmo_back_run", 4'b0000);

    // ---------------- clr_stats wins over a coincident increment
    load_use();
    clr_stats = 1;
    #1 chk_ctl("clr_hzd", 4'b1010);
    @(negedge clk);
    exp_cnt = 0;
    chk_cnt("clr_cnt");
    chk_err("clr_err", 1'b0);
    clr_stats = 0;

    // ---------------- saturation on the 2-bit instance
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_cnt += 1;
      chk_cnt("sat_cnt");
    end

    // ---------------- reset in the middle of MEM_WAIT
    idle();
    mem_req = 1;
    @(negedge clk);
    load_use();
    #1 rst = 0;
    #1 chk_ctl("rst_mid_ctl", 4'b0000);
    chk_fwd("rst_mid_fwd", 4'b0000);
    exp_cnt = 0;
    chk_cnt("rst_mid_cnt");
    chk_err("rst_mid_err", 1'b0);
    @(negedge clk);
    rst = 1;
    idle();
    #1 chk_ctl("rst_mid_run", 4'b0000);
    @(negedge clk);
    chk_cnt("rst_mid_cnt2");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
